// File: rtl/spi_job_controller.sv
// Two-port SPI job sequencer: counts bits on the global (SPI0) and daisy (SPI1) ports,
// strobes completed words, starts/halts the worker core and drives the READY pull-down enable.
//
// state  | meaning
// IDLE   | waiting for a global frame
// GLOBAL | receiving the job broadcast on SPI0
// DAISY  | job loaded, receiving per-node data on SPI1
// RUN    | core is searching
// FOUND  | result held, READY pulled low until the host reads it out
// ERROR  | bad frame length, only a new global frame recovers
module spi_job_controller #(
    parameter int WORD_BITS    = 32,
    parameter int GLOBAL_WORDS = 8,
    parameter int DAISY_WORDS  = 1,
    localparam int GIDX_W      = (GLOBAL_WORDS > 1) ? $clog2(GLOBAL_WORDS) : 1
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic              cs0_n_in,
    input  logic              sck0_rise_in,
    input  logic              cs1_n_in,
    input  logic              sck1_rise_in,
    input  logic              core_found_in,
    input  logic              core_done_in,
    output logic              global_word_out,
    output logic [GIDX_W-1:0] global_index_out,
    output logic              daisy_word_out,
    output logic              core_start_out,
    output logic              core_halt_out,
    output logic              ready_oe_out,
    output logic              busy_out,
    output logic              frame_error_out,
    output logic [2:0]        state_out
);
    localparam int G_BITS = GLOBAL_WORDS * WORD_BITS;
    localparam int D_BITS = DAISY_WORDS * WORD_BITS;
    localparam int G_CW   = $clog2(G_BITS) + 1;
    localparam int D_CW   = $clog2(D_BITS) + 1;
    localparam logic [G_CW-1:0] G_FULL = G_CW'(G_BITS);
    localparam logic [G_CW-1:0] G_OVER = G_CW'(G_BITS + 1);
    localparam logic [D_CW-1:0] D_FULL = D_CW'(D_BITS);
    localparam logic [D_CW-1:0] D_OVER = D_CW'(D_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GLOBAL = 3'd1,
        ST_DAISY  = 3'd2,
        ST_RUN    = 3'd3,
        ST_FOUND  = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    state_t            state;
    logic              cs0_q, cs1_q;
    logic              cs0_fall, cs0_rise, cs1_fall, cs1_rise;
    logic [G_CW-1:0]   g_cnt, g_cnt_nxt;
    logic [D_CW-1:0]   d_cnt, d_cnt_nxt;
    logic              g_inc, d_inc;
    logic              g_word, d_word;
    logic [GIDX_W-1:0] g_idx;
    logic              g_exact, d_exact;

    assign cs0_fall = cs0_q && !cs0_n_in;
    assign cs0_rise = !cs0_q && cs0_n_in;
    assign cs1_fall = cs1_q && !cs1_n_in;
    assign cs1_rise = !cs1_q && cs1_n_in;

    // A pulse coinciding with the CS falling edge is the first bit of the new frame.
    always_comb begin
        g_cnt_nxt = g_cnt;
        g_inc     = 1'b0;
        if (cs0_fall) begin
            g_cnt_nxt = sck0_rise_in ? G_CW'(1) : '0;
            g_inc     = sck0_rise_in;
        end else if (!cs0_n_in && sck0_rise_in && g_cnt != G_OVER) begin
            g_cnt_nxt = g_cnt + G_CW'(1);
            g_inc     = 1'b1;
        end
    end

    always_comb begin
        d_cnt_nxt = d_cnt;
        d_inc     = 1'b0;
        if (cs1_fall) begin
            d_cnt_nxt = sck1_rise_in ? D_CW'(1) : '0;
            d_inc     = sck1_rise_in;
        end else if (!cs1_n_in && sck1_rise_in && d_cnt != D_OVER) begin
            d_cnt_nxt = d_cnt + D_CW'(1);
            d_inc     = 1'b1;
        end
    end

    assign g_word  = g_inc && ((int'(g_cnt_nxt) % WORD_BITS) == 0) && (g_cnt_nxt != G_OVER);
    assign d_word  = d_inc && ((int'(d_cnt_nxt) % WORD_BITS) == 0) && (d_cnt_nxt != D_OVER);
    assign g_idx   = GIDX_W'(int'(g_cnt_nxt) / WORD_BITS - 1);
    assign g_exact = (g_cnt == G_FULL);
    assign d_exact = (d_cnt == D_FULL);

    // CS history resets to deasserted so a CS held low through reset reads as a fresh frame start.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cs0_q            <= 1'b1;
            cs1_q            <= 1'b1;
            g_cnt            <= '0;
            d_cnt            <= '0;
            global_word_out  <= 1'b0;
            global_index_out <= '0;
            daisy_word_out   <= 1'b0;
        end else begin
            cs0_q           <= cs0_n_in;
            cs1_q           <= cs1_n_in;
            g_cnt           <= g_cnt_nxt;
            d_cnt           <= d_cnt_nxt;
            global_word_out <= g_word;
            daisy_word_out  <= d_word;
            if (g_word) begin
                global_index_out <= g_idx;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state           <= ST_IDLE;
            core_start_out  <= 1'b0;
            core_halt_out   <= 1'b0;
            ready_oe_out    <= 1'b0;
            frame_error_out <= 1'b0;
        end else begin
            core_start_out <= 1'b0;
            core_halt_out  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!cs0_n_in) begin
                        state <= ST_GLOBAL;
                    end
                end
                ST_GLOBAL: begin
                    if (cs0_rise) begin
                        if (g_exact) begin
                            state <= ST_DAISY;
                        end else begin
                            state           <= ST_ERROR;
                            frame_error_out <= 1'b1;
                        end
                    end
                end
                ST_DAISY: begin
                    if (cs0_fall) begin
                        state <= ST_GLOBAL;
                    end else if (cs1_rise) begin
                        if (d_exact) begin
                            state          <= ST_RUN;
                            core_start_out <= 1'b1;
                        end else begin
                            state           <= ST_ERROR;
                            frame_error_out <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // a new job preempts any result arriving in the same cycle
                    if (cs0_fall) begin
                        state         <= ST_GLOBAL;
                        core_halt_out <= 1'b1;
                    end else if (core_found_in) begin
                        state        <= ST_FOUND;
                        ready_oe_out <= 1'b1;
                    end else if (core_done_in) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FOUND: begin
                    if (cs0_fall) begin
                        state         <= ST_GLOBAL;
                        core_halt_out <= 1'b1;
                        ready_oe_out  <= 1'b0;
                    end else if (cs1_rise && d_exact) begin
                        state        <= ST_IDLE;
                        ready_oe_out <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    if (cs0_fall) begin
                        state           <= ST_GLOBAL;
                        frame_error_out <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_out  = (state == ST_RUN);
    assign state_out = state;

endmodule

// File: tb/tb_spi_job_controller.sv
// Bench for spi_job_controller: frame-length table, hand-written corner sequences and
// randomized jobs checked every cycle against a frame-level reference model.
module tb_spi_job_controller;
    localparam int WB   = 32;
    localparam int GMAX = 8 * WB;
    localparam int DMAX = 1 * WB;

    logic       clk_in = 1'b0;
    logic       reset_n_in;
    logic       cs0_n_in, sck0_rise_in, cs1_n_in, sck1_rise_in;
    logic       core_found_in, core_done_in;
    logic       global_word_out;
    logic [2:0] global_index_out;
    logic       daisy_word_out, core_start_out, core_halt_out;
    logic       ready_oe_out, busy_out, frame_error_out;
    logic [2:0] state_out;

    spi_job_controller dut (
        .clk_in           (clk_in),
        .reset_n_in       (reset_n_in),
        .cs0_n_in         (cs0_n_in),
        .sck0_rise_in     (sck0_rise_in),
        .cs1_n_in         (cs1_n_in),
        .sck1_rise_in     (sck1_rise_in),
        .core_found_in    (core_found_in),
        .core_done_in     (core_done_in),
        .global_word_out  (global_word_out),
        .global_index_out (global_index_out),
        .daisy_word_out   (daisy_word_out),
        .core_start_out   (core_start_out),
        .core_halt_out    (core_halt_out),
        .ready_oe_out     (ready_oe_out),
        .busy_out         (busy_out),
        .frame_error_out  (frame_error_out),
        .state_out        (state_out)
    );

    always #5 clk_in = ~clk_in;

    int n_pass = 0;
    int n_total = 0;

    // reference model: states 0..5 as numbered in the datasheet, bit counts as plain integers
    int m_state, m_c0, m_c1, m_idx;
    bit m_p0, m_p1, m_err, m_gw, m_dw, m_start, m_halt;

    bit c0, c1, fnd;
    int gw_seen, dw_seen;
    int idx_q[$];

    typedef struct {
        int g;
        int d;
        int st;
        int err;
        int gw;
        int dw;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [12:0] exp_vec();
        logic [2:0] st, ix;
        st = 3'(m_state);
        ix = 3'(m_idx);
        return {m_gw, ix, m_dw, m_start, m_halt, (m_state == 4), (m_state == 3), m_err, st};
    endfunction

    function automatic logic [12:0] act_vec();
        return {global_word_out, global_index_out, daisy_word_out, core_start_out, core_halt_out,
                ready_oe_out, busy_out, frame_error_out, state_out};
    endfunction

    task automatic model_reset();
        m_state = 0; m_c0 = 0; m_c1 = 0; m_idx = 0;
        m_p0 = 1; m_p1 = 1; m_err = 0;
        m_gw = 0; m_dw = 0; m_start = 0; m_halt = 0;
    endtask

    task automatic model_step(input bit cs0, input bit sck0, input bit cs1, input bit sck1,
                              input bit found, input bit done);
        bit f0, r0, f1, r1;
        int nxt;
        f0 = m_p0 && !cs0;  r0 = !m_p0 && cs0;
        f1 = m_p1 && !cs1;  r1 = !m_p1 && cs1;
        m_gw = 0; m_dw = 0; m_start = 0; m_halt = 0;
        nxt = m_state;
        case (m_state)
            0: if (!cs0) nxt = 1;
            1: if (r0) begin
                   if (m_c0 == GMAX) nxt = 2;
                   else begin nxt = 5; m_err = 1; end
               end
            2: if (f0) nxt = 1;
               else if (r1) begin
                   if (m_c1 == DMAX) begin nxt = 3; m_start = 1; end
                   else begin nxt = 5; m_err = 1; end
               end
            3: if (f0) begin nxt = 1; m_halt = 1; end
               else if (found) nxt = 4;
               else if (done) nxt = 0;
            4: if (f0) begin nxt = 1; m_halt = 1; end
               else if (r1 && m_c1 == DMAX) nxt = 0;
            5: if (f0) begin nxt = 1; m_err = 0; end
            default: nxt = 0;
        endcase
        if (f0) m_c0 = sck0 ? 1 : 0;
        else if (!cs0 && sck0 && m_c0 <= GMAX) begin
            m_c0++;
            if (m_c0 % WB == 0 && m_c0 <= GMAX) begin m_gw = 1; m_idx = m_c0 / WB - 1; end
        end
        if (f1) m_c1 = sck1 ? 1 : 0;
        else if (!cs1 && sck1 && m_c1 <= DMAX) begin
            m_c1++;
            if (m_c1 % WB == 0 && m_c1 <= DMAX) m_dw = 1;
        end
        m_state = nxt;
        m_p0 = cs0;
        m_p1 = cs1;
    endtask

    task automatic step(input bit cs0, input bit sck0, input bit cs1, input bit sck1,
                        input bit found, input bit done);
        cs0_n_in = cs0; sck0_rise_in = sck0;
        cs1_n_in = cs1; sck1_rise_in = sck1;
        core_found_in = found; core_done_in = done;
        @(posedge clk_in);
        model_step(cs0, sck0, cs1, sck1, found, done);
        #1;
        if (global_word_out) begin gw_seen++; idx_q.push_back(int'(global_index_out)); end
        if (daisy_word_out) dw_seen++;
        check("cycle", int'(act_vec()), int'(exp_vec()));
    endtask

    task automatic pulse(input int port, input bit s, input bit noise);
        bit n;
        n = noise && ($urandom_range(0, 1) == 1);
        step(c0, port == 0 ? s : n, c1, port == 1 ? s : n, fnd, 1'b0);
    endtask

    task automatic frame(input int port, input int n, input bit rnd);
        bit edge_sck;
        int left;
        edge_sck = rnd && n > 0 && ($urandom_range(0, 1) == 1);
        if (port == 0) c0 = 0; else c1 = 0;
        pulse(port, edge_sck, rnd);
        left = edge_sck ? n - 1 : n;
        for (int i = 0; i < left; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) pulse(port, 1'b0, rnd);
            pulse(port, 1'b1, rnd);
        end
        if (port == 0) c0 = 1; else c1 = 1;
        pulse(port, rnd && ($urandom_range(0, 1) == 1), rnd);
    endtask

    task automatic do_reset();
        #2 reset_n_in = 1'b0;
        #1;
        check("async_reset", int'(act_vec()), 0);
        c0 = 1; c1 = 1; fnd = 0;
        cs0_n_in = 1; cs1_n_in = 1; sck0_rise_in = 0; sck1_rise_in = 0;
        core_found_in = 0; core_done_in = 0;
        model_reset();
        @(posedge clk_in);
        #1 reset_n_in = 1'b1;
    endtask

    task automatic full_job();
        frame(0, GMAX, 1'b0);
        frame(1, DMAX, 1'b0);
    endtask

    initial begin
        int g, d, k, r;
        tbl[0] = '{256, 32, 3, 0, 8, 1};
        tbl[1] = '{255, 32, 5, 1, 7, 1};
        tbl[2] = '{257, 32, 5, 1, 8, 1};
        tbl[3] = '{256, 31, 5, 1, 8, 0};
        tbl[4] = '{256, 33, 5, 1, 8, 1};
        tbl[5] = '{0,   32, 5, 1, 0, 1};
        tbl[6] = '{96,  0,  5, 1, 3, 0};

        reset_n_in = 1'b1;
        do_reset();

        for (int i = 0; i < 7; i++) begin
            do_reset();
            gw_seen = 0; dw_seen = 0;
            frame(0, tbl[i].g, 1'b0);
            frame(1, tbl[i].d, 1'b0);
            check($sformatf("tbl%0d_state", i), int'(state_out), tbl[i].st);
            check($sformatf("tbl%0d_err", i), int'(frame_error_out), tbl[i].err);
            check($sformatf("tbl%0d_gwords", i), gw_seen, tbl[i].gw);
            check($sformatf("tbl%0d_dwords", i), dw_seen, tbl[i].dw);
        end

        // nominal job and result readout
        do_reset();
        idx_q.delete(); gw_seen = 0;
        frame(0, GMAX, 1'b0);
        check("nominal_gwords", gw_seen, 8);
        for (int i = 0; i < 8; i++) check("nominal_index", i < idx_q.size() ? idx_q[i] : -1, i);
        frame(1, DMAX, 1'b0);
        check("nominal_start", int'(core_start_out), 1);
        check("nominal_state", int'(state_out), 3);
        pulse(0, 1'b0, 1'b0);
        check("start_single", int'(core_start_out), 0);
        fnd = 1;
        pulse(0, 1'b0, 1'b0);
        check("found_ready", int'(ready_oe_out), 1);
        check("found_state", int'(state_out), 4);
        fnd = 0;
        frame(1, 31, 1'b0);
        check("bad_readout_state", int'(state_out), 4);
        frame(1, DMAX, 1'b0);
        check("readout_ready", int'(ready_oe_out), 0);
        check("readout_state", int'(state_out), 0);

        // found beats done; done alone returns to idle
        full_job();
        step(c0, 0, c1, 0, 1'b1, 1'b1);
        check("found_over_done", int'(state_out), 4);
        do_reset();
        full_job();
        step(c0, 0, c1, 0, 1'b0, 1'b1);
        check("done_idle", int'(state_out), 0);

        // preemption: cs0 falls as core_found rises
        do_reset();
        full_job();
        c0 = 0;
        step(c0, 0, c1, 0, 1'b1, 1'b0);
        check("preempt_halt", int'(core_halt_out), 1);
        check("preempt_state", int'(state_out), 1);
        check("preempt_ready", int'(ready_oe_out), 0);
        repeat (GMAX) pulse(0, 1'b1, 1'b0);
        c0 = 1;
        pulse(0, 1'b0, 1'b0);
        check("preempt_reload", int'(state_out), 2);

        // SCK coinciding with CS edges: counted on fall, ignored on rise
        do_reset();
        c0 = 0;
        pulse(0, 1'b1, 1'b0);
        repeat (GMAX - 1) pulse(0, 1'b1, 1'b0);
        c0 = 1;
        pulse(0, 1'b1, 1'b0);
        check("edge_sck_state", int'(state_out), 2);
        c0 = 0;
        pulse(0, 1'b0, 1'b0);
        check("daisy_new_job", int'(state_out), 1);

        // error recovery
        do_reset();
        frame(0, GMAX + 1, 1'b0);
        check("long_err", int'(frame_error_out), 1);
        c0 = 0;
        pulse(0, 1'b0, 1'b0);
        check("err_clear_state", int'(state_out), 1);
        check("err_clear_flag", int'(frame_error_out), 0);

        // async reset mid-frame in GLOBAL, then in FOUND
        do_reset();
        c0 = 0;
        pulse(0, 1'b0, 1'b0);
        repeat (100) pulse(0, 1'b1, 1'b0);
        do_reset();
        full_job();
        check("after_reset_g", int'(state_out), 3);
        fnd = 1;
        pulse(0, 1'b0, 1'b0);
        check("pre_reset_found", int'(ready_oe_out), 1);
        do_reset();
        full_job();
        check("after_reset_f", int'(state_out), 3);

        // randomized jobs against the model
        for (int j = 0; j < 40; j++) begin
            fnd = 0;
            r = $urandom_range(0, 9);
            g = r < 6 ? GMAX : r == 6 ? GMAX - 1 : r == 7 ? GMAX + 1 : $urandom_range(0, GMAX + 4);
            frame(0, g, 1'b1);
            r = $urandom_range(0, 9);
            d = r < 6 ? DMAX : r == 6 ? DMAX - 1 : r == 7 ? DMAX + 1 : $urandom_range(0, DMAX + 4);
            frame(1, d, 1'b1);
            repeat ($urandom_range(0, 5)) pulse(0, 1'b0, 1'b1);
            k = $urandom_range(0, 3);
            case (k)
                0: step(c0, 0, c1, 0, fnd, 1'b1);
                1: begin
                    fnd = 1;
                    repeat ($urandom_range(1, 4)) pulse(0, 1'b0, 1'b1);
                    frame(1, ($urandom_range(0, 1) == 1) ? DMAX : DMAX - 1, 1'b1);
                    frame(1, DMAX, 1'b1);
                    fnd = 0;
                end
                2: ;
                default: begin
                    step(c0, 0, c1, 0, 1'b1, 1'b1);
                    frame(1, DMAX, 1'b1);
                end
            endcase
            repeat ($urandom_range(0, 4)) pulse(0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/spi_job_controller.md
# spi_job_controller

Sequences the two-port SPI job interface of a chained worker node. It frames and counts bits on the global port (SPI0, job broadcast) and the daisy port (SPI1, per-node data), and strobes completed words into the shift buffers. It starts and halts the worker core and drives the enable of the shared open-drain READY line. It sits between the SPI shift front-ends and the core, and owns all protocol state.

## Interface
- WORD_BITS, 32, bits per SPI word.
- GLOBAL_WORDS, 8, words in a valid global frame.
- DAISY_WORDS, 1, words in a valid daisy frame.
- clk_in  input  1  system clock; all logic on its rising edge.
- reset_n_in  input  1  reset, asynchronous and active-low.
- cs0_n_in  input  1  global chip select, active-low, already synchronized to clk_in.
- sck0_rise_in  input  1  one-cycle pulse per SCK0 rising edge, from the front-end synchronizer.
- cs1_n_in  input  1  daisy chip select, active-low, synchronized.
- sck1_rise_in  input  1  one-cycle pulse per SCK1 rising edge.
- core_found_in  input  1  level: core has a result.
- core_done_in  input  1  one-cycle pulse: core exhausted its work range without a result.
- global_word_out  output  1  one-cycle strobe: a global word is complete.
- global_index_out  output  $clog2(GLOBAL_WORDS) (minimum 1)  index of the strobed global word.
- daisy_word_out  output  1  one-cycle strobe: a daisy word is complete.
- core_start_out  output  1  one-cycle pulse that starts the core.
- core_halt_out  output  1  one-cycle pulse that aborts the core.
- ready_oe_out  output  1  1 = pull READY low; 0 = high-Z (tristate is external).
- busy_out  output  1  high in RUN.
- frame_error_out  output  1  sticky flag for a bad frame length.
- state_out  output  3  current state encoding.

## Operation
- States and encoding: IDLE=0, GLOBAL=1, DAISY=2, RUN=3, FOUND=4, ERROR=5.
- Bit counter: one per port, width $clog2(WORDS*WORD_BITS)+1. Clears when its CS asserts. Increments on the SCK pulse while CS is low. Saturates at WORDS*WORD_BITS+1, which marks an overrun.
- Word strobe: fires on every WORD_BITS-th increment. The global word index is the count divided by WORD_BITS, minus 1. Saturated edges produce no strobe.
- IDLE: cs0 low -> GLOBAL. cs1 activity is ignored.
- GLOBAL: cs0 rising with count == GLOBAL_WORDS*WORD_BITS -> DAISY. Any other count -> ERROR.
- DAISY:
  - cs1 rising with count == DAISY_WORDS*WORD_BITS -> RUN, with core_start pulsed. Any other count -> ERROR.
  - cs0 falling -> GLOBAL. The new job replaces the old one.
- RUN:
  - core_found high -> FOUND.
  - core_done -> IDLE.
  - cs0 falling -> pulse core_halt and go to GLOBAL.
- FOUND:
  - ready_oe is high.
  - A complete daisy frame (cs1 rising, count exact) -> IDLE, and ready_oe drops. This is the host reading out the result.
  - A bad-length readout stays in FOUND.
  - cs0 falling -> core_halt, then GLOBAL.
- ERROR:
  - frame_error is set on entry.
  - cs0 falling -> GLOBAL and clears frame_error.
  - Nothing else leaves ERROR.
- Simultaneous events:
  - In RUN, cs0 falling wins over core_found and core_done. The core halts and the result is discarded.
  - core_found wins over core_done.
  - A CS edge and an SCK pulse in the same cycle: the edge is processed and the SCK pulse is counted only if CS is low after the edge.
- Reset (asynchronous, including mid-frame): state = IDLE, counters = 0, all outputs = 0, so ready_oe is released immediately. No halt pulse is issued; the core is reset separately.

## Timing
- All outputs are registered.
- global_word_out and daisy_word_out assert the cycle after the completing SCK pulse.
- A state change occurs the cycle after the qualifying input.
- core_start and core_halt are single-cycle and coincide with the first cycle of the new state.
- ready_oe asserts the cycle after core_found is first sampled high, and deasserts the cycle after the readout cs1 rising edge.
- state_out and busy_out follow the state register with no extra delay.
- Throughput: SCK pulses may arrive every clock cycle. No edge is lost.

## Test plan
- Nominal job:
  - Stimulus: 256 SCK0 pulses under cs0, release; 32 SCK1 pulses under cs1, release.
  - Response: 8 global strobes with index 0..7; 1 daisy strobe; core_start one cycle after the cs1 release; state 3.
- Result path:
  - Stimulus: in RUN, raise core_found; later, run a 32-bit daisy readout.
  - Response: ready_oe rises one cycle after core_found, state 4; after the readout, ready_oe falls and state returns to 0.
- Short and long frames:
  - Stimulus: 255 SCK0 pulses; separately, 257 pulses.
  - Response: ERROR (5) with frame_error=1 in both cases; no 9th strobe; the next cs0 assert clears the flag and enters state 1.
- Preemption:
  - Stimulus: in RUN, drop cs0 in the same cycle core_found rises.
  - Response: core_halt pulse, state 1, ready_oe stays 0.
- Async reset:
  - Stimulus: assert reset_n low mid-frame in GLOBAL, and separately in FOUND.
  - Response: all outputs 0 and state 0 within the same cycle, with no clock edge needed; a fresh full job then succeeds.
